cic_interpolator: RTL and testbench

Cascaded integrator-comb (CIC) interpolator: upsamples an AXI-stream sample stream by a runtime-selectable integer rate R (1..RMAX) using N comb stages at the input rate, zero-stuffing, and N integrator stages at the output rate. It is the transmit-side counterpart to the team's CIC decimator and uses the same parameter set and `rate` port semantics, so the two can be paired in up/down-conversion chains. No multipliers are used; gain is (R·M)^N / R, and downstream scaling is the consumer's job.

---
 rtl/cic_interpolator.sv | 95 +++++++++
 tb/tb_cic_interpolator.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cic_interpolator.sv
// CIC interpolator: N comb stages at the input rate, zero-stuffing by a runtime
// rate R (1..RMAX), N integrator stages at the output rate. Gain is (R*M)^N / R.
module cic_interpolator #(
    parameter int WIDTH     = 16,
    parameter int RMAX      = 2,
    parameter int M         = 1,
    parameter int N         = 2,
    parameter int REG_WIDTH = WIDTH + $clog2((RMAX * M) ** N)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic        [WIDTH-1:0]     input_tdata,
    input  logic                        input_tvalid,
    output logic                        input_tready,
    output logic signed [REG_WIDTH-1:0] output_tdata,
    output logic                        output_tvalid,
    input  logic                        output_tready,
    input  logic [$clog2(RMAX+1)-1:0]   rate
);

    localparam int RATE_W = $clog2(RMAX + 1);
    localparam logic [RATE_W:0] RMAX_EXT = (RATE_W + 1)'(RMAX);

    // Handshake: an output beat is offered whenever a new sample is presented at
    // phase 0 or a zero-stuffed beat is pending (phase != 0); output_tvalid never
    // looks at output_tready. A beat transfers on output_tvalid & output_tready,
    // and an input transfers only on the phase-0 beat of that same handshake.
    logic [RATE_W-1:0] cycle_reg;
    logic              phase_zero;
    logic              transfer_in;
    logic              transfer_out;
    logic [RATE_W:0]   cycle_inc;
    logic              cycle_wrap;

    logic signed [REG_WIDTH-1:0] comb_reg  [N];
    logic signed [REG_WIDTH-1:0] delay_reg [N][M];
    logic signed [REG_WIDTH-1:0] integ_reg [N];
    logic signed [REG_WIDTH-1:0] comb_x    [N];
    logic signed [REG_WIDTH-1:0] stuff_val;

    assign phase_zero    = (cycle_reg == '0);
    assign input_tready  = output_tready & phase_zero;
    assign output_tvalid = input_tvalid | ~phase_zero;
    assign transfer_in   = input_tvalid & input_tready;
    assign transfer_out  = output_tready & output_tvalid;
    assign output_tdata  = integ_reg[N-1];

    // rate 0 behaves as 1 and rates above RMAX as RMAX: compare phase+1 against both.
    assign cycle_inc  = {1'b0, cycle_reg} + {{RATE_W{1'b0}}, 1'b1};
    assign cycle_wrap = !((cycle_inc < RMAX_EXT) && (cycle_inc < {1'b0, rate}));

    assign stuff_val = phase_zero ? comb_reg[N-1] : '0;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            comb_x[k] = '0;
        end
        comb_x[0] = REG_WIDTH'($signed(input_tdata));
        for (int k = 1; k < N; k++) begin
            comb_x[k] = comb_reg[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_reg <= '0;
            for (int k = 0; k < N; k++) begin
                comb_reg[k]  <= '0;
                integ_reg[k] <= '0;
                for (int j = 0; j < M; j++) begin
                    delay_reg[k][j] <= '0;
                end
            end
        end else begin
            if (transfer_in) begin
                for (int k = 0; k < N; k++) begin
                    comb_reg[k]     <= comb_x[k] - delay_reg[k][M-1];
                    delay_reg[k][0] <= comb_x[k];
                    for (int j = 1; j < M; j++) begin
                        delay_reg[k][j] <= delay_reg[k][j-1];
                    end
                end
            end
            if (transfer_out) begin
                // Integrators wrap modulo 2^REG_WIDTH; the comb differences cancel it.
                integ_reg[0] <= integ_reg[0] + stuff_val;
                for (int k = 1; k < N; k++) begin
                    integ_reg[k] <= integ_reg[k] + integ_reg[k-1];
                end
                cycle_reg <= cycle_wrap ? '0 : cycle_inc[RATE_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator (N=2, M=1, RMAX=2): impulse/step tables,
// rate boundaries, backpressure, input starvation and mid-stream reset.
module tb_cic_interpolator;

    localparam int WIDTH     = 16;
    localparam int RMAX      = 2;
    localparam int M         = 1;
    localparam int N         = 2;
    localparam int REG_WIDTH = 18;
    localparam int RATE_W    = 2;

    logic                        clk = 1'b0;
    logic                        rst;
    logic        [WIDTH-1:0]     input_tdata;
    logic                        input_tvalid;
    logic                        input_tready;
    logic signed [REG_WIDTH-1:0] output_tdata;
    logic                        output_tvalid;
    logic                        output_tready;
    logic [RATE_W-1:0]           rate;

    int n_cmp = 0;
    int n_bad = 0;
    logic [REG_WIDTH-1:0] exp_q[$];

    // Hand-computed responses, one entry per accepted output beat.
    int imp2[12]     = '{0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0};
    int imp1[12]     = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    int step2[12]    = '{0, 0, 0, 0, 0, 0, 1, 2, 2, 2, 2, 2};
    int step2_neg[12] = '{0, 0, 0, 0, 0, 0, -32768, -65536, -65536, -65536, -65536, -65536};

    cic_interpolator #(
        .WIDTH(WIDTH), .RMAX(RMAX), .M(M), .N(N), .REG_WIDTH(REG_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .input_tdata(input_tdata),
        .input_tvalid(input_tvalid),
        .input_tready(input_tready),
        .output_tdata(output_tdata),
        .output_tvalid(output_tvalid),
        .output_tready(output_tready),
        .rate(rate)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int as_int(input logic [REG_WIDTH-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic load_exp(input int vals[12], input int count);
        exp_q.delete();
        for (int i = 0; i < count; i++) begin
            exp_q.push_back(REG_WIDTH'(vals[i]));
        end
    endtask

    task automatic reset_dut();
        rst           = 1'b1;
        input_tvalid  = 1'b0;
        output_tready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Driver + scoreboard: drives one cycle per iteration, tracks its own phase
    // and pops exp_q on every beat that should transfer.
    task automatic run_stream(input int reff, input int first, input int rest,
                              input bit bp, input bit starve, input int budget);
        int  phase = 0;
        int  in_cnt = 0;
        bit  prev_stall = 1'b0;
        int  prev_data = 0;
        bit  v;
        bit  r;
        bit  exp_tv;
        int  got;
        for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
            r = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            v = starve ? ($urandom_range(0, 2) != 0) : 1'b1;
            output_tready = r;
            input_tvalid  = v;
            input_tdata   = WIDTH'((in_cnt == 0) ? first : rest);
            #4;
            exp_tv = v | (phase != 0);
            check_val("tvalid", int'(output_tvalid), int'(exp_tv));
            check_val("tready", int'(input_tready), int'(r & (phase == 0)));
            got = as_int(output_tdata);
            if (prev_stall) check_val("hold", got, prev_data);
            if (exp_tv && r) begin
                check_val("beat", got, as_int(exp_q.pop_front()));
                if (phase == 0) in_cnt++;
                phase = (phase + 1 == reff) ? 0 : phase + 1;
            end
            prev_stall = !r;
            prev_data  = got;
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            check_val("timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        rst           = 1'b1;
        input_tvalid  = 1'b0;
        input_tdata   = '0;
        output_tready = 1'b0;
        rate          = 2'd2;
        @(posedge clk);
        #1;

        // Reset state: tvalid follows input_tvalid, tready follows output_tready.
        input_tvalid  = 1'b1;
        output_tready = 1'b0;
        #4;
        check_val("rst_tdata", as_int(output_tdata), 0);
        check_val("rst_tvalid_hi", int'(output_tvalid), 1);
        check_val("rst_tready_lo", int'(input_tready), 0);
        @(posedge clk);
        #1;
        input_tvalid  = 1'b0;
        output_tready = 1'b1;
        #4;
        check_val("rst_tvalid_lo", int'(output_tvalid), 0);
        check_val("rst_tready_hi", int'(input_tready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Impulse and step responses at R=2
        rate = 2'd2;
        load_exp(imp2, 12);
        run_stream(2, 1, 0, 1'b0, 1'b0, 60);
        reset_dut();
        load_exp(step2, 12);
        run_stream(2, 1, 1, 1'b0, 1'b0, 60);
        reset_dut();
        load_exp(step2_neg, 12);
        run_stream(2, -32768, -32768, 1'b0, 1'b0, 60);

        // Rate boundaries: 1 and 0 mean R=1, 3 clamps to RMAX
        rate = 2'd1;
        reset_dut();
        load_exp(imp1, 12);
        run_stream(1, 1, 0, 1'b0, 1'b0, 60);
        rate = 2'd0;
        reset_dut();
        load_exp(imp1, 12);
        run_stream(1, 1, 0, 1'b0, 1'b0, 60);
        rate = 2'd3;
        reset_dut();
        load_exp(imp2, 12);
        run_stream(2, 1, 0, 1'b0, 1'b0, 60);

        // Backpressure, starvation, and both together
        rate = 2'd2;
        reset_dut();
        load_exp(step2, 12);
        run_stream(2, 1, 1, 1'b1, 1'b0, 300);
        reset_dut();
        load_exp(imp2, 12);
        run_stream(2, 1, 0, 1'b0, 1'b1, 300);
        reset_dut();
        load_exp(step2, 12);
        run_stream(2, 1, 1, 1'b1, 1'b1, 400);

        // Mid-stream reset: stop at phase 1 with nonzero state, pulse rst once
        reset_dut();
        load_exp(step2, 7);
        run_stream(2, 1, 1, 1'b0, 1'b0, 60);
        rst           = 1'b1;
        input_tvalid  = 1'b1;
        output_tready = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        input_tvalid = 1'b0;
        #4;
        check_val("mid_rst_tdata", as_int(output_tdata), 0);
        check_val("mid_rst_tvalid", int'(output_tvalid), 0);
        check_val("mid_rst_tready", int'(input_tready), 1);
        @(posedge clk);
        #1;
        load_exp(step2, 12);
        run_stream(2, 1, 1, 1'b0, 1'b0, 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
